// File: rtl/piso_pkg.sv
// piso_pkg: shared state encoding and count-width helper for the PISO/SIPO pair
package piso_pkg;
  typedef enum logic {ST_IDLE, ST_SHIFT} state_t;
  function automatic int cnt_w(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction
endpackage

// File: rtl/piso_bit_cnt.sv
// piso_bit_cnt: modulo-WIDTH bit counter with clear, enable and last-bit flag
module piso_bit_cnt
  import piso_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic last
);
  localparam int CW = cnt_w(WIDTH);
  logic [CW-1:0] cnt;
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    if (rst || clr) cnt <= '0;
    else if (en) cnt <= last ? '0 : cnt + 1'b1;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: parallel-in serial-out transmitter with valid/ready load and done pulse
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] parallel_in,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             busy,
  output logic             done
);
  state_t state;
  logic [WIDTH-1:0] sr;
  logic last, take;
  assign busy         = state == ST_SHIFT;
  assign serial_valid = busy;
  assign done         = busy && last;
  assign load_ready   = !rst && (!busy || last);
  assign take         = load_valid && load_ready;
  assign serial_out   = busy && (MSB_FIRST ? sr[WIDTH-1] : sr[0]);
  piso_bit_cnt #(.WIDTH(WIDTH)) u_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (take),
    .en   (busy),
    .last (last)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= ST_IDLE;
      sr    <= '0;
    end else if (take) begin
      state <= ST_SHIFT;
      sr    <= parallel_in;
    end else if (busy) begin
      sr    <= MSB_FIRST ? {sr[WIDTH-2:0], 1'b0} : {1'b0, sr[WIDTH-1:1]};
      state <= last ? ST_IDLE : ST_SHIFT;
    end
endmodule

// File: tb/tb_piso_tx.sv
// tb_piso_tx: MSB- and LSB-first instances against a queue-of-pending-bits model
module tb_piso_tx;
  localparam int W = 4;
  logic clk = 0, rst = 1, lv = 0;
  logic [W-1:0] pin = '0;
  logic rdy_m, so_m, sv_m, busy_m, done_m;
  logic rdy_l, so_l, sv_l, busy_l, done_l;
  logic [W-1:0] rx_m, rx_l, rx_exp;
  logic rx_pend = 0;
  logic [1:0] qm[$], ql[$];
  logic [W-1:0] wq[$];
  int n_chk = 0, n_err = 0;
  always #5 clk = ~clk;
  piso_tx #(.WIDTH(W), .MSB_FIRST(1)) dut_m (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rdy_m), .parallel_in(pin),
    .serial_out(so_m), .serial_valid(sv_m), .busy(busy_m), .done(done_m)
  );
  piso_tx #(.WIDTH(W), .MSB_FIRST(0)) dut_l (
    .clk(clk), .rst(rst), .load_valid(lv), .load_ready(rdy_l), .parallel_in(pin),
    .serial_out(so_l), .serial_valid(sv_l), .busy(busy_l), .done(done_l)
  );
  always @(posedge clk) begin
    if (sv_m) rx_m <= {rx_m[W-2:0], so_m};
    if (sv_l) rx_l <= {so_l, rx_l[W-1:1]};
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic step(input logic r, input logic v, input logic [W-1:0] w);
    logic rdy;
    logic [1:0] fm, fl;
    rst = r;
    lv  = v;
    pin = w;
    #1;
    fm  = (qm.size() != 0) ? qm[0] : 2'b00;
    fl  = (ql.size() != 0) ? ql[0] : 2'b00;
    rdy = !r && qm.size() <= 1;
    chk("ready_m", 32'(rdy_m), 32'(rdy));
    chk("ready_l", 32'(rdy_l), 32'(rdy));
    chk("valid_m", 32'(sv_m), 32'(qm.size() != 0));
    chk("valid_l", 32'(sv_l), 32'(ql.size() != 0));
    chk("busy_m", 32'(busy_m), 32'(qm.size() != 0));
    chk("busy_l", 32'(busy_l), 32'(ql.size() != 0));
    chk("bit_m", 32'(so_m), 32'(fm[0]));
    chk("bit_l", 32'(so_l), 32'(fl[0]));
    chk("done_m", 32'(done_m), 32'(fm[1]));
    chk("done_l", 32'(done_l), 32'(fl[1]));
    if (rx_pend) begin
      chk("rx_m", 32'(rx_m), 32'(rx_exp));
      chk("rx_l", 32'(rx_l), 32'(rx_exp));
      rx_pend = 0;
    end
    if (r) begin
      qm.delete();
      ql.delete();
      wq.delete();
    end else begin
      if (fm[1] && wq.size() != 0) begin
        rx_exp  = wq.pop_front();
        rx_pend = 1;
      end
      if (qm.size() != 0) void'(qm.pop_front());
      if (ql.size() != 0) void'(ql.pop_front());
      if (v && rdy) begin
        wq.push_back(w);
        for (int i = 0; i < W; i++) begin
          qm.push_back({i == W - 1, w[W-1-i]});
          ql.push_back({i == W - 1, w[i]});
        end
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    step(1, 0, '0);
    step(0, 0, '0);
    step(0, 1, 4'b1011);
    repeat (6) step(0, 0, '0);
    step(0, 1, 4'b1011);
    repeat (3) step(0, 0, '0);
    step(0, 1, 4'b0110);
    repeat (5) step(0, 0, '0);
    step(0, 1, 4'b0000);
    repeat (4) step(0, 1, 4'b1111);
    repeat (6) step(0, 0, '0);
    step(0, 1, 4'b1100);
    repeat (2) step(0, 0, '0);
    step(1, 0, '0);
    repeat (3) step(0, 0, '0);
    for (int k = 0; k < 400; k++)
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1, W'($urandom));
    repeat (6) step(0, 0, '0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/piso_tx.md
Name: piso_tx

Overview:
- Parallel-in, serial-out transmitter: the sending end for the team's serial-in/parallel-out shift register.
- Accepts a WIDTH-bit word through a valid/ready handshake and drives it out one bit per clock with a qualifying valid strobe.
- Pulses done on the last bit. Supports gapless back-to-back words.
- Sits between a parallel producer (register file, FIFO) and a serial link or a SIPO receiver.

Parameters:
- WIDTH, 4, word width in bits; must be >= 2.
- MSB_FIRST, 1, 1 = transmit bit WIDTH-1 first; 0 = transmit bit 0 first.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- load_valid  input  1  producer has a word on parallel_in.
- load_ready  output  1  block can accept a word this cycle.
- parallel_in  input  WIDTH  word to transmit; sampled only on handshake.
- serial_out  output  1  current serial bit.
- serial_valid  output  1  serial_out carries a frame bit this cycle.
- busy  output  1  a frame is in progress (state SHIFT).
- done  output  1  one-cycle pulse while the last bit of a frame is presented.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset:
  - rst high at an edge sets state IDLE, the shift register to 0 and bit count to 0.
  - Outputs in the cycle after that edge: serial_out=0, serial_valid=0, busy=0, done=0.
  - load_ready is forced 0 while rst is high and is 1 in the first cycle after reset is released.
- States:
  - IDLE: serial_valid=0, serial_out=0, load_ready=1.
  - SHIFT: serial_valid=1; serial_out = shift register bit WIDTH-1 if MSB_FIRST, else bit 0.
- Handshake:
  - A transfer occurs at an edge where load_valid && load_ready.
  - That edge captures parallel_in into the shift register, clears the count and moves to SHIFT.
- Latency: the first bit appears in the cycle after the accepting edge. WIDTH bits occupy WIDTH consecutive cycles with no gaps.
- SHIFT operation:
  - Each edge shifts the register one place toward the output end, fills the vacated bit with 0, and increments the count.
  - The count is $clog2(WIDTH) bits wide and runs 0..WIDTH-1.
- Last bit (count == WIDTH-1):
  - done=1 and load_ready=1 in that cycle.
  - With no load at the next edge, go to IDLE with serial_out=0.
  - With a load at that edge (back-to-back): reload, count=0, stay in SHIFT. serial_valid stays high with no bubble, and done goes low for the new word's first bit.
- Loads in non-last SHIFT cycles: load_ready=0, so load_valid is ignored and parallel_in is not sampled. The producer must hold its word.
- Reset mid-frame: the frame is aborted at the reset edge; no done pulse, and no residual bits are emitted afterwards.
- Output timing: serial_out, serial_valid, busy and done derive only from registered state and count (no input-to-output combinational path). load_ready depends only on state, count and rst.

Decomposition:
- Package piso_pkg:
  - State enum: ST_IDLE, ST_SHIFT.
  - Helper constant function for the count width.
- Sub-module piso_bit_cnt: parameterised modulo-WIDTH counter with clear, enable and a last flag. It is reusable by the matching receiver.
- The FSM and shift register stay in piso_tx.

Test Plan:
1. Reset, then load 4'b1011 with MSB_FIRST=1 -> serial_out 1,0,1,1 in the 4 cycles after the handshake; serial_valid high exactly 4 cycles; done high on the 4th only; then IDLE with serial_out=0.
2. MSB_FIRST=0, load 4'b1011 -> serial_out 1,1,0,1; done on the 4th bit.
3. Back-to-back: 4'b1011, then 4'b0110 held valid during the last bit -> 8 contiguous valid bits 1,0,1,1,0,1,1,0; done on cycles 4 and 8; busy never drops between words.
4. load_valid high with 4'b1111 during bits 1-3 of a 4'b0000 frame -> load_ready=0; frame emits 0,0,0,0; the 1111 word is accepted only at the last-bit edge.
5. rst asserted after the 2nd bit of 4'b1100 -> next cycle serial_valid=0, busy=0, done never pulses; load_ready=1 once rst drops.
6. Loopback: serial_out feeds a SIPO (WIDTH=4) receiver, with MSB_FIRST chosen to match its shift direction; load 4'b1011 -> the receiver's parallel_out equals 4'b1011 in the cycle after done.
